demux_logic_unit: RTL

//  Parametrised, pipelined bitwise logic unit; every gate is built from 1:2 demux primitives
//  (d0 = ~s & x, d1 = s & x), extending the combinational demux AND/OR/NOT cell to 8 ops.

---
 rtl/demux_logic_unit_if.sv | 27 ++
 rtl/demux_logic_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/demux_logic_unit_if.sv
// Handshake bundle for demux_logic_unit: input beat channel, result channel and busy flag.
interface demux_logic_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_sweep;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [2:0]       out_op;
  logic             out_last;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_op, in_sweep, out_ready,
    input  in_ready, out_valid, out_y, out_op, out_last, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_sweep, out_ready,
    output in_ready, out_valid, out_y, out_op, out_last, busy
  );
endinterface

// File: rtl/demux_logic_unit.sv
// Pipelined bitwise logic unit whose gates are all built from 1:2 demux cells;
// SWEEP mode expands one operand pair into all 8 op results in order.
module demux_logic_unit #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  demux_logic_unit_if.slave dlu
);
  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [WIDTH-1:0] ONES = '1;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_lat_a, r_lat_b;

  logic             r_s1_valid, r_s1_last;
  logic [WIDTH-1:0] r_s1_a, r_s1_b;
  logic [2:0]       r_s1_op;

  logic             r_out_valid, r_out_last;
  logic [WIDTH-1:0] r_out_y;
  logic [2:0]       r_out_op;

  logic             w_s2_adv, w_s1_load, w_acc, w_inj;
  logic [WIDTH-1:0] w_and, w_or, w_xor, w_y;

  function automatic logic [WIDTH-1:0] dmx0(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] x);
    return ~s & x;
  endfunction

  function automatic logic [WIDTH-1:0] dmx1(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] x);
    return s & x;
  endfunction

  assign w_s2_adv  = !r_out_valid || dlu.out_ready;
  assign w_s1_load = w_s2_adv || !r_s1_valid;
  assign w_acc     = dlu.in_valid && dlu.in_ready;
  assign w_inj     = (r_state == SWEEP) && w_s1_load;

  assign dlu.in_ready  = !rst && (r_state == IDLE) && w_s1_load;
  assign dlu.busy      = (r_state == SWEEP);
  assign dlu.out_valid = r_out_valid;
  assign dlu.out_y     = r_out_y;
  assign dlu.out_op    = r_out_op;
  assign dlu.out_last  = r_out_last;

  // OR = a&1 | ~a&b, XOR = ~a&b | ~b&a; inverted ops demux the base result against all-ones.
  always_comb begin
    w_and = dmx1(r_s1_a, r_s1_b);
    w_or  = dmx1(r_s1_a, ONES) | dmx0(r_s1_a, r_s1_b);
    w_xor = dmx0(r_s1_a, r_s1_b) | dmx0(r_s1_b, r_s1_a);
    w_y   = '0;
    case (r_s1_op)
      3'd0:    w_y = w_and;
      3'd1:    w_y = w_or;
      3'd2:    w_y = dmx0(r_s1_a, ONES);
      3'd3:    w_y = dmx0(w_and, ONES);
      3'd4:    w_y = dmx0(w_or, ONES);
      3'd5:    w_y = w_xor;
      3'd6:    w_y = dmx0(w_xor, ONES);
      default: w_y = dmx1(r_s1_a, ONES);
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_acc && dlu.in_sweep) begin
          w_state_nxt = SWEEP;
          w_cnt_nxt   = 3'd1;
        end
      end
      SWEEP: begin
        if (w_s1_load) begin
          if (r_cnt == 3'd7) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_lat_a <= '0;
      r_lat_b <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_acc && dlu.in_sweep) begin
        r_lat_a <= dlu.in_a;
        r_lat_b <= dlu.in_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
      r_s1_last  <= 1'b0;
    end else if (w_acc) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= dlu.in_a;
      r_s1_b     <= dlu.in_b;
      r_s1_op    <= dlu.in_sweep ? 3'd0 : dlu.in_op;
      r_s1_last  <= !dlu.in_sweep;
    end else if (w_inj) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= r_lat_a;
      r_s1_b     <= r_lat_b;
      r_s1_op    <= r_cnt;
      r_s1_last  <= (r_cnt == 3'd7);
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_op    <= '0;
      r_out_last  <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_y    <= w_y;
        r_out_op   <= r_s1_op;
        r_out_last <= r_s1_last;
      end
    end
  end
endmodule
